mainfsm: RTL and testbench
==========================

# mainfsm

Multicycle RISC-V main controller FSM. It sequences each instruction through Fetch/Decode/Execute/Memory/Writeback. It produces the `ALUOp` code consumed by `aludec`, plus all datapath mux selects and write strobes. It sits in the multicycle controller next to `aludec` and the immediate-select decoder. `Branch` is ANDed with the ALU `Zero` flag outside this block.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op`  in  7  opcode field `instr[6:0]`, taken from the instruction register.
- `PCUpdate`  out  1  unconditional PC write strobe.
- `Branch`  out  1  conditional PC write request.
- `RegWrite`  out  1  register file write strobe.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  instruction/OldPC register write strobe.
- `ResultSrc`  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA`  out  2  A mux: 00 PC, 01 OldPC, 10 rs1 data.
- `ALUSrcB`  out  2  B mux: 00 rs2 data, 01 ImmExt, 10 constant 4.
- `AdrSrc`  out  1  memory address: 0 PC, 1 Result.
- `ALUOp`  out  2  to `aludec`: 00 add, 01 subtract, 10 funct-decoded.
- `illegal_op`  out  1  one-cycle flag for an unsupported opcode.

## Operation
Supported opcodes:
- 0000011 lw
- 0100011 sw
- 0110011 R-type
- 0010011 I-type ALU
- 1101111 jal
- 1100011 beq

Outputs are Moore, decoded from state only. Any signal not listed for a state is 0.

States and outputs:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Precomputes the branch target.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.

Transitions (all on the rising edge of `clk`):
- FETCH -> DECODE.
- DECODE, by `op`:
  - lw or sw -> MEMADR
  - R-type -> EXECUTER
  - I-type -> EXECUTEI
  - jal -> JAL
  - beq -> BEQ
  - anything else -> FETCH, with `illegal_op`=1 during that DECODE cycle. The instruction is treated as a NOP.
- MEMADR -> MEMREAD when `op`=lw, otherwise MEMWRITE.
- MEMREAD -> MEMWB -> FETCH.
- MEMWRITE -> FETCH.
- EXECUTER and EXECUTEI -> ALUWB -> FETCH.
- JAL -> ALUWB.
- BEQ -> FETCH.
- An unreachable state encoding -> FETCH on the next edge. All outputs are 0 in that cycle.

`op` is sampled combinationally in DECODE and MEMADR only. It is a don't-care in every other state.

## Timing
- Reset asserted: state = FETCH immediately, with no clock needed. While `reset`=1:
  - all strobes (`PCUpdate`, `IRWrite`, `RegWrite`, `MemWrite`, `Branch`, `illegal_op`) are forced to 0;
  - mux selects and `ALUOp` show the FETCH values.
- First cycle after deassertion: FETCH with strobes active.
- Reset asserted mid-instruction: the instruction is abandoned and no further strobes are issued. If `reset` rises during MEMWRITE, `MemWrite` drops combinationally.
- Cycles per instruction, counting from FETCH through the last state before the next FETCH:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
  - illegal opcode: 2
- Exactly one register-state update per clock. No handshakes and no stalls: memory is single-cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - state enum `statetype_t` (FETCH..BEQ, 4-bit);
  - opcode localparams (`OP_LW`, `OP_SW`, `OP_R`, `OP_I`, `OP_JAL`, `OP_BEQ`);
  - `ALUOp` encodings (`ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`);
  - `ResultSrc`, `ALUSrcA` and `ALUSrcB` select encodings.
- Internal organisation: single module with one state register, one next-state combinational block and one output-decode combinational block. No sub-module. `aludec` and the immediate decoder are siblings, instantiated by the enclosing controller.

## Test plan
- Reset sequence:
  - Stimulus: assert `reset` mid-cycle with no clock edge, hold 2 cycles, then release.
  - Required: all strobes 0 and `ALUSrcB`=10 during reset; first edge after release shows `IRWrite`=`PCUpdate`=1.
- lw:
  - Stimulus: `op`=0000011.
  - Required: FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `AdrSrc`=1 in MEMREAD; `RegWrite`=1 with `ResultSrc`=01 in cycle 5; next cycle is FETCH.
- sw, then beq:
  - Stimulus: `op`=0100011, then 1100011.
  - Required: sw gives `MemWrite`=1 only in cycle 4. beq gives `Branch`=1 and `ALUOp`=01 in cycle 3 and never `RegWrite`.
- R-type, I-type, jal:
  - Stimulus: `op`=0110011, 0010011 and 1101111 in turn.
  - Required: `ALUOp`=10 in EXECUTER/EXECUTEI with `ALUSrcB`=00 (R) or 01 (I). jal: `PCUpdate`=1 in cycle 3, ALUWB in cycle 4.
- Illegal opcode:
  - Stimulus: `op`=0000000 in DECODE.
  - Required: `illegal_op`=1 for exactly that cycle, next state FETCH, no `RegWrite`/`MemWrite`.
- Reset mid-instruction:
  - Stimulus: assert `reset` during MEMWRITE.
  - Required: `MemWrite` falls the same cycle; after release the FSM restarts at FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the multicycle RISC-V controller
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } statetype_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_DATA   = 2'b01;
  localparam logic [1:0] RESULT_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle RISC-V main controller FSM
module mainfsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       AdrSrc,
  output logic [1:0] ALUOp,
  output logic       illegal_op
);

  statetype_t state, nextstate;
  logic       op_known;

  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I)  || (op == OP_JAL) || (op == OP_BEQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextstate;
  end

  always_comb begin
    nextstate = FETCH;
    case (state)
      FETCH:    nextstate = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_R:         nextstate = EXECUTER;
          OP_I:         nextstate = EXECUTEI;
          OP_JAL:       nextstate = JAL;
          OP_BEQ:       nextstate = BEQ;
          default:      nextstate = FETCH;
        endcase
      end
      MEMADR:   nextstate = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  nextstate = MEMWB;
      MEMWB:    nextstate = FETCH;
      MEMWRITE: nextstate = FETCH;
      EXECUTER: nextstate = ALUWB;
      EXECUTEI: nextstate = ALUWB;
      ALUWB:    nextstate = FETCH;
      JAL:      nextstate = ALUWB;
      BEQ:      nextstate = FETCH;
      default:  nextstate = FETCH;
    endcase
  end

  // Selects follow the state; strobes are additionally masked while reset is high.
  always_comb begin
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RESULT_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    AdrSrc     = 1'b0;
    ALUOp      = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RESULT_ALURES;
        PCUpdate  = 1'b1;
      end
      DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        illegal_op = ~op_known;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RESULT_DATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: RegWrite = 1'b1;
      JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCUpdate = 1'b1;
      end
      BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        Branch  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - self-checking bench for mainfsm
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

  int checks = 0;
  int errors = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AdrSrc(AdrSrc),
    .ALUOp(ALUOp), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  wire [14:0] act = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, AdrSrc, ALUOp, illegal_op};

  function automatic logic [14:0] ov(input logic pc, br, rw, mw, ir,
                                     input logic [1:0] rs, sa, sb,
                                     input logic ad, input logic [1:0] ao,
                                     input logic il);
    return {pc, br, rw, mw, ir, rs, sa, sb, ad, ao, il};
  endfunction

  logic [14:0] exp_q[$];

  task automatic chk(input string name, input logic [14:0] a, input logic [14:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, a, e);
    end
  endtask

  task automatic chk_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, a, e);
    end
  endtask

  // Expected per-cycle output sequence of one instruction, straight from the state table.
  task automatic model_seq(input logic [6:0] o);
    logic [14:0] dec;
    dec = ov(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0);
    exp_q.delete();
    exp_q.push_back(ov(1,0,0,0,1, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0));
    case (o)
      7'b0000011: begin
        exp_q.push_back(dec);
        exp_q.push_back(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0));
        exp_q.push_back(ov(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
        exp_q.push_back(ov(0,0,1,0,0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0));
      end
      7'b0100011: begin
        exp_q.push_back(dec);
        exp_q.push_back(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0));
        exp_q.push_back(ov(0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
      end
      7'b0110011: begin
        exp_q.push_back(dec);
        exp_q.push_back(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0));
        exp_q.push_back(ov(0,0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
      end
      7'b0010011: begin
        exp_q.push_back(dec);
        exp_q.push_back(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0));
        exp_q.push_back(ov(0,0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
      end
      7'b1101111: begin
        exp_q.push_back(dec);
        exp_q.push_back(ov(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0));
        exp_q.push_back(ov(0,0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
      end
      7'b1100011: begin
        exp_q.push_back(dec);
        exp_q.push_back(ov(0,1,0,0,0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 0));
      end
      default: exp_q.push_back(dec | 15'd1);
    endcase
  endtask

  // op only matters in the 2nd and 3rd cycles; elsewhere it is scrambled.
  task automatic run_instr(input logic [6:0] o, input int upto, input string name);
    int n;
    model_seq(o);
    n = (upto < 0 || upto > exp_q.size()) ? exp_q.size() : upto;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op = (i == 1 || i == 2) ? o : 7'($urandom);
      #1;
      chk($sformatf("%s op=%b cyc%0d", name, o, i + 1), act, exp_q[i]);
    end
  endtask

  typedef struct {
    logic [6:0] op;
    int cycles;
    int n_rw;
    int n_mw;
    int n_br;
    int n_il;
  } vec_t;

  vec_t vecs[8];

  task automatic run_count(input vec_t v);
    int cyc, rw, mw, br, il;
    bit done;
    cyc = 0; rw = 0; mw = 0; br = 0; il = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      op = v.op;
      #1;
      cyc++;
      rw += int'(RegWrite);
      mw += int'(MemWrite);
      br += int'(Branch);
      il += int'(illegal_op);
      @(posedge clk);
      #1;
      if (IRWrite) done = 1;
      else if (cyc >= 10) begin
        chk_int($sformatf("timeout op=%b", v.op), cyc, v.cycles);
        done = 1;
      end
    end
    chk_int($sformatf("cpi op=%b", v.op), cyc, v.cycles);
    chk_int($sformatf("regwrite op=%b", v.op), rw, v.n_rw);
    chk_int($sformatf("memwrite op=%b", v.op), mw, v.n_mw);
    chk_int($sformatf("branch op=%b", v.op), br, v.n_br);
    chk_int($sformatf("illegal op=%b", v.op), il, v.n_il);
  endtask

  logic [14:0] reset_vec, fetch_vec;
  logic [6:0]  legal[6];

  initial begin
    reset_vec = ov(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0);
    fetch_vec = ov(1,0,0,0,1, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0);
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    vecs[0] = '{7'b0000011, 5, 1, 0, 0, 0};
    vecs[1] = '{7'b0100011, 4, 0, 1, 0, 0};
    vecs[2] = '{7'b0110011, 4, 1, 0, 0, 0};
    vecs[3] = '{7'b0010011, 4, 1, 0, 0, 0};
    vecs[4] = '{7'b1101111, 4, 1, 0, 0, 0};
    vecs[5] = '{7'b1100011, 3, 0, 0, 1, 0};
    vecs[6] = '{7'b0000000, 2, 0, 0, 0, 1};
    vecs[7] = '{7'b1111111, 2, 0, 0, 0, 1};

    // Reset raised between edges must take effect without a clock.
    #2 reset = 1'b1;
    #1 chk("reset async", act, reset_vec);
    repeat (2) begin
      @(negedge clk);
      #1 chk("reset held", act, reset_vec);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("reset release fetch", act, fetch_vec);

    foreach (legal[i]) run_instr(legal[i], -1, "directed");
    run_instr(7'b0000000, -1, "directed illegal");
    run_instr(7'b0000011, -1, "after illegal");

    for (int i = 0; i < 8; i++) run_count(vecs[i]);

    // Reset during MEMWRITE kills the write in the same cycle.
    run_instr(7'b0100011, 3, "sw pre-reset");
    @(negedge clk);
    op = 7'($urandom);
    #1 chk("memwrite before reset", act, ov(0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
    reset = 1'b1;
    #1 chk("memwrite dropped by reset", act, reset_vec);
    @(posedge clk);
    @(posedge clk);
    #1 chk("reset held mid", act, reset_vec);
    reset = 1'b0;
    #1 chk("restart fetch", act, fetch_vec);
    run_instr(7'b1100011, -1, "post-reset beq");

    for (int k = 0; k < 60; k++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 4) == 0) ? 7'($urandom) : legal[$urandom_range(0, 5)];
      run_instr(o, -1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
